// File: rtl/w_realign_stage.sv
// Store-data realignment: rotates the packed W stream by the start-address byte
// offset, builds per-beat strobes and last, and emits the trailing flush beat.
module w_realign_stage #(
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned NumTrackers  = 4,
    parameter int unsigned LenWidth     = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [AxiAddrWidth-1:0]   cmd_addr_i,
    input  logic [LenWidth-1:0]       cmd_nbytes_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [AxiDataWidth-1:0]   w_data_i,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    output logic [AxiDataWidth-1:0]   w_data_o,
    output logic [AxiDataWidth/8-1:0] w_strb_o,
    output logic                      w_last_o
);
    localparam int unsigned B    = AxiDataWidth / 8;
    localparam int unsigned OffW = $clog2(B);
    localparam int unsigned PtrW = (NumTrackers > 1) ? $clog2(NumTrackers) : 1;
    localparam int unsigned CntW = $clog2(NumTrackers) + 1;
    localparam int unsigned SumW = LenWidth + 1;
    localparam int unsigned ShW  = OffW + 4;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, FLUSH} state_e;

    // ---------------------------------------------------------------- command FIFO
    logic [OffW-1:0]     fifo_off_q [NumTrackers];
    logic [LenWidth-1:0] fifo_len_q [NumTrackers];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q;
    logic                rdy_en_q;
    logic                push, pop;

    logic addr_unused;
    assign addr_unused = ^cmd_addr_i[AxiAddrWidth-1:OffW];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(NumTrackers - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // rdy_en_q keeps cmd_ready_o low while in reset and for the first edge after it
    assign cmd_ready_o = rdy_en_q && (count_q != CntW'(NumTrackers));
    assign push        = cmd_valid_i && cmd_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
            for (int i = 0; i < int'(NumTrackers); i++) begin
                fifo_off_q[i] <= '0;
                fifo_len_q[i] <= '0;
            end
        end else begin
            rdy_en_q <= 1'b1;
            if (push) begin
                fifo_off_q[wr_ptr_q] <= cmd_addr_i[OffW-1:0];
                fifo_len_q[wr_ptr_q] <= cmd_nbytes_i;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    // ---------------------------------------------------------------- burst geometry
    logic [OffW-1:0]     head_off;
    logic [LenWidth-1:0] head_len;
    logic [SumW-1:0]     end_sum;
    logic [LenWidth-1:0] n_in, n_out;

    assign head_off = fifo_off_q[rd_ptr_q];
    assign head_len = fifo_len_q[rd_ptr_q];
    assign end_sum  = SumW'(head_off) + SumW'(head_len);
    assign n_in     = LenWidth'((SumW'(head_len) + SumW'(B - 1)) >> OffW);
    assign n_out    = LenWidth'((end_sum + SumW'(B - 1)) >> OffW);

    // ---------------------------------------------------------------- FSM
    state_e                state_q, state_d;
    logic [OffW-1:0]       off_q, end_q;
    logic [LenWidth-1:0]   in_left_q, out_left_q;
    logic                  first_q;
    logic [AxiDataWidth-1:0] hold_q;
    logic                  w_hs, more_cmds;

    assign w_hs      = (state_q == STREAM) && w_valid_i && w_ready_i;
    assign more_cmds = (count_q != '0);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (more_cmds) state_d = LOAD;
            LOAD: begin
                pop = 1'b1;
                if (head_len == '0) state_d = (count_q > CntW'(1)) ? LOAD : IDLE;
                else                state_d = STREAM;
            end
            STREAM: begin
                if (w_hs && in_left_q == LenWidth'(1)) begin
                    if (out_left_q == LenWidth'(1)) state_d = more_cmds ? LOAD : IDLE;
                    else                            state_d = FLUSH;
                end
            end
            FLUSH: if (w_ready_i) state_d = more_cmds ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            off_q      <= '0;
            end_q      <= '0;
            in_left_q  <= '0;
            out_left_q <= '0;
            first_q    <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: begin
                    off_q      <= head_off;
                    end_q      <= end_sum[OffW-1:0];
                    in_left_q  <= n_in;
                    out_left_q <= n_out;
                    first_q    <= 1'b1;
                    hold_q     <= '0;
                end
                STREAM: begin
                    if (w_hs) begin
                        hold_q     <= w_data_i;
                        in_left_q  <= in_left_q - LenWidth'(1);
                        out_left_q <= out_left_q - LenWidth'(1);
                        first_q    <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (w_ready_i) begin
                        out_left_q <= '0;
                        first_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- datapath
    logic                    active, last_beat;
    logic [AxiDataWidth-1:0] cur, rotated;
    logic [OffW+2:0]         lsh;
    logic [ShW-1:0]          rsh;
    logic [B-1:0]            ones, lo_mask, hi_mask, strb;

    always_comb begin
        w_valid_o = 1'b0;
        w_ready_o = 1'b0;
        active    = 1'b0;
        cur       = '0;
        case (state_q)
            STREAM: begin
                w_valid_o = w_valid_i;
                w_ready_o = w_ready_i;
                active    = 1'b1;
                cur       = w_data_i;
            end
            // the flush beat carries only the tail bytes left in hold_q
            FLUSH: begin
                w_valid_o = 1'b1;
                active    = 1'b1;
            end
            default: ;
        endcase
    end

    assign lsh = {off_q, 3'b000};
    assign rsh = ShW'(AxiDataWidth) - ShW'(lsh);

    always_comb begin
        if (off_q == '0) rotated = cur;
        else             rotated = (cur << lsh) | (hold_q >> rsh);
    end

    assign last_beat = (out_left_q == LenWidth'(1));
    assign ones      = '1;
    assign lo_mask   = ones << off_q;
    assign hi_mask   = (end_q == '0) ? ones : ~(ones << end_q);

    always_comb begin
        strb = ones;
        if (first_q)   strb = strb & lo_mask;
        if (last_beat) strb = strb & hi_mask;
    end

    assign w_data_o = active ? rotated : '0;
    assign w_strb_o = active ? strb : '0;
    assign w_last_o = w_valid_o && last_beat;

endmodule

// File: tb/tb_w_realign_stage.sv
// Bench for w_realign_stage: byte-level model places stream byte i at output
// byte off+i and checks every beat, including stalled cycles.
module tb_w_realign_stage;
    localparam int DW = 128;
    localparam int B  = DW / 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [63:0]   cmd_addr_i = '0;
    logic [15:0]   cmd_nbytes_i = '0;
    logic          w_valid_i = 1'b0;
    logic          w_ready_o;
    logic [DW-1:0] w_data_i = '0;
    logic          w_valid_o;
    logic          w_ready_i = 1'b0;
    logic [DW-1:0] w_data_o;
    logic [B-1:0]  w_strb_o;
    logic          w_last_o;

    w_realign_stage #(
        .AxiDataWidth(DW), .AxiAddrWidth(64), .NumTrackers(4), .LenWidth(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_nbytes_i(cmd_nbytes_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
        .w_strb_o(w_strb_o), .w_last_o(w_last_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          nbytes;
    } cmd_t;

    int          checks = 0;
    int          errors = 0;
    cmd_t        cmd_q[$];
    logic [7:0]  sb [0:511];
    logic [15:0] seen_strb[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [63:0] addr, input int nbytes);
        int   t;
        cmd_t c;
        t = 0;
        @(negedge clk);
        cmd_valid_i  = 1'b1;
        cmd_addr_i   = addr;
        cmd_nbytes_i = 16'(nbytes);
        #1;
        while (!cmd_ready_o && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!cmd_ready_o) begin
            checks++;
            errors++;
            $error("FAIL push_timeout addr=%0h cmd_ready_o=%0b expected=1", addr, cmd_ready_o);
            cmd_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        c.addr   = addr;
        c.nbytes = nbytes;
        cmd_q.push_back(c);
    endtask

    // stall_mode: 0 always ready, 1 random ready, 2 ready low for 5 cycles on the flush beat
    task automatic run_burst(input bit incr_data, input int stall_mode, input int exp_lat);
        cmd_t          c;
        int            off, n_in, n_out, waited, vtries, p, idx;
        bit            done;
        logic [DW-1:0] ed;
        logic [B-1:0]  es;
        seen_strb.delete();
        if (cmd_q.size() == 0) return;
        c = cmd_q.pop_front();
        if (c.nbytes == 0) return;
        off   = int'(c.addr[3:0]);
        n_in  = (c.nbytes + B - 1) / B;
        n_out = (off + c.nbytes + B - 1) / B;
        for (int i = 0; i < n_in * B; i++) sb[i] = incr_data ? 8'(i) : 8'($urandom);
        waited = 0;
        for (int m = 0; m < n_out; m++) begin
            ed = '0;
            es = '0;
            for (int j = 0; j < B; j++) begin
                p   = m * B + j;
                idx = p - off;
                if (idx >= 0 && idx < n_in * B) ed[j*8 +: 8] = sb[idx];
                es[j] = (p >= off) && (p < off + c.nbytes);
            end
            done   = 1'b0;
            vtries = 0;
            while (!done) begin
                @(negedge clk);
                w_valid_i = (m < n_in);
                for (int j = 0; j < B; j++)
                    w_data_i[j*8 +: 8] = (m < n_in) ? sb[m*B + j] : 8'($urandom);
                case (stall_mode)
                    0:       w_ready_i = 1'b1;
                    1:       w_ready_i = ($urandom_range(0, 2) != 0);
                    default: w_ready_i = !(m >= n_in && vtries < 5);
                endcase
                #1;
                if (w_valid_o) begin
                    if (m == 0 && vtries == 0 && exp_lat >= 0) chk("first_latency", DW'(waited), DW'(exp_lat));
                    chk("data", w_data_o, ed);
                    chk("strb", DW'(w_strb_o), DW'(es));
                    chk("last", DW'(w_last_o), DW'(m == n_out - 1));
                    chk("ready_o", DW'(w_ready_o), DW'((m < n_in) && w_ready_i));
                    vtries++;
                    if (w_ready_i) begin
                        seen_strb.push_back(w_strb_o);
                        done = 1'b1;
                    end
                end else begin
                    if (m > 0) chk("valid_mid_burst", DW'(w_valid_o), DW'(1));
                    waited++;
                    if (waited > 40) begin
                        checks++;
                        errors++;
                        $error("FAIL beat_timeout beat=%0d w_valid_o=%0b expected=1", m, w_valid_o);
                        w_valid_i = 1'b0;
                        w_ready_i = 1'b0;
                        return;
                    end
                end
                @(posedge clk);
            end
        end
        #1;
        w_valid_i = 1'b0;
        w_ready_i = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, DW'(w_valid_o), '0);
        chk({tag, "_ready"}, DW'(w_ready_o), '0);
        chk({tag, "_last"},  DW'(w_last_o),  '0);
        chk({tag, "_strb"},  DW'(w_strb_o),  '0);
        chk({tag, "_data"},  w_data_o,       '0);
        chk({tag, "_cmd_ready"}, DW'(cmd_ready_o), '0);
    endtask

    int hs;

    initial begin
        // reset state
        #2;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_ni = 1'b1;
        #1 chk("cmd_ready_at_release", DW'(cmd_ready_o), '0);
        @(posedge clk);
        #1 chk("cmd_ready_after_release", DW'(cmd_ready_o), DW'(1));

        // aligned, two beats, no flush
        push_cmd(64'h1000, 32);
        run_burst(1'b0, 0, 2);
        chk("aligned_nbeats", DW'(seen_strb.size()), DW'(2));
        chk("aligned_strb0", DW'(seen_strb[0]), DW'(16'hFFFF));
        chk("aligned_strb1", DW'(seen_strb[1]), DW'(16'hFFFF));
        @(negedge clk);
        #1 chk("aligned_no_flush", DW'(w_valid_o), '0);

        // misaligned single input beat with extra flush beat, stalled 5 cycles
        push_cmd(64'h1003, 16);
        run_burst(1'b1, 2, -1);
        chk("mis_nbeats", DW'(seen_strb.size()), DW'(2));
        chk("mis_strb0", DW'(seen_strb[0]), DW'(16'hFFF8));
        chk("mis_strb1", DW'(seen_strb[1]), DW'(16'h0007));

        // single-beat partial
        push_cmd(64'h100C, 4);
        run_burst(1'b1, 1, -1);
        chk("single_nbeats", DW'(seen_strb.size()), DW'(1));
        chk("single_strb", DW'(seen_strb[0]), DW'(16'hF000));

        // zero-length followed by a three-beat burst
        push_cmd(64'h2000, 0);
        push_cmd(64'h2005, 40);
        run_burst(1'b0, 0, -1);
        run_burst(1'b0, 1, -1);
        chk("b2b_nbeats", DW'(seen_strb.size()), DW'(3));
        chk("b2b_strb0", DW'(seen_strb[0]), DW'(16'hFFE0));
        chk("b2b_strb1", DW'(seen_strb[1]), DW'(16'hFFFF));
        chk("b2b_strb2", DW'(seen_strb[2]), DW'(16'h1FFF));

        // FIFO full while the first burst sits in STREAM without data
        push_cmd(64'h4001, 40);
        repeat (3) @(posedge clk);
        push_cmd(64'h4102, 20);
        push_cmd(64'h4200, 16);
        push_cmd(64'h430F, 1);
        push_cmd(64'h4404, 28);
        @(negedge clk);
        #1 chk("fifo_full", DW'(cmd_ready_o), '0);
        run_burst(1'b0, 0, -1);
        @(negedge clk);
        #1 chk("full_until_pop", DW'(cmd_ready_o), '0);
        @(posedge clk);
        #1 chk("ready_after_pop", DW'(cmd_ready_o), DW'(1));
        push_cmd(64'h450A, 50);
        while (cmd_q.size() > 0) run_burst(1'b0, 1, -1);
        chk("wrap_last_strb", DW'(seen_strb[seen_strb.size()-1]), DW'(16'h0FFF));

        // reset pulsed mid-burst with another command still queued
        push_cmd(64'h3007, 64);
        push_cmd(64'h3100, 16);
        hs = 0;
        for (int t = 0; t < 30 && hs < 2; t++) begin
            @(negedge clk);
            w_valid_i = 1'b1;
            w_ready_i = 1'b1;
            w_data_i  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (w_valid_o) hs++;
            if (hs < 2) @(posedge clk);
        end
        chk("pre_reset_streaming", DW'(w_valid_o), DW'(1));
        rst_ni = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        w_valid_i = 1'b0;
        w_ready_i = 1'b0;
        cmd_q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        #1 chk("midrst_cmd_ready_release", DW'(cmd_ready_o), '0);
        @(posedge clk);
        #1 chk("midrst_cmd_ready_after", DW'(cmd_ready_o), DW'(1));
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            w_valid_i = 1'b1;
            w_ready_i = 1'b1;
            #1 chk("fifo_emptied", DW'(w_valid_o), '0);
        end
        w_valid_i = 1'b0;
        w_ready_i = 1'b0;
        push_cmd(64'h5009, 30);
        run_burst(1'b0, 0, 2);
        chk("fresh_nbeats", DW'(seen_strb.size()), DW'(3));

        // randomized bursts, sometimes two queued at once
        for (int i = 0; i < 15; i++) begin
            push_cmd({$urandom, $urandom}, int'($urandom_range(1, 100)));
            if (i % 3 == 0) push_cmd({$urandom, $urandom}, int'($urandom_range(1, 100)));
            while (cmd_q.size() > 0) run_burst(1'b0, 1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/w_realign_stage.md
# w_realign_stage

Store-data realignment stage for the vector store path. Cluster VLSUs emit W data packed, with element 0 at byte 0. This block rotates that stream to match the byte offset of the store's start address, and generates per-beat byte strobes and `last`. It emits the extra trailing beat needed when a misaligned store straddles one more bus word than it occupies. It sits between the cluster store-data output and the system-side W channel, mirroring the read-side alignment stages.

## Interface
- `AxiDataWidth`, 128: W data width in bits; B = AxiDataWidth/8 bytes, power of 2, ≥ 16.
- `AxiAddrWidth`, 64: address width.
- `NumTrackers`, 4: depth of the command queue, power of 2.
- `LenWidth`, 16: width of the byte-count field.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `cmd_valid_i` in 1: store command valid; one command per AW burst issued to memory.
- `cmd_ready_o` out 1: command accepted.
- `cmd_addr_i` in AxiAddrWidth: start byte address; off = `cmd_addr_i[log2(B)-1:0]`.
- `cmd_nbytes_i` in LenWidth: total payload bytes of the burst.
- `w_valid_i` in 1: packed store data valid.
- `w_ready_o` out 1: packed store data accepted.
- `w_data_i` in AxiDataWidth: packed data, stream byte k*B+j at beat k, byte j.
- `w_valid_o` out 1: aligned beat valid.
- `w_ready_i` in 1: downstream accept.
- `w_data_o` out AxiDataWidth: aligned data.
- `w_strb_o` out B: byte strobes.
- `w_last_o` out 1: last beat of the burst.

## Operation
- **Command FIFO.**
  - `NumTrackers` entries, each holding {off, nbytes}.
  - `cmd_ready_o` = (count_q != NumTrackers), based on registered count only.
  - Push and pop in the same cycle leave the count unchanged.
- **Per-burst values.**
  - n_in = ceil(nbytes/B).
  - n_out = ceil((off+nbytes)/B).
  - End byte e = (off+nbytes) mod B, with e = 0 meaning full.
  - Counters in_left and out_left are loaded from n_in and n_out; both are LenWidth wide.
  - nbytes = 0: the command is popped in LOAD and produces no beats.
- **Held register.** `hold_q` stores the previous accepted input beat; it is cleared on LOAD.
- **Output data.** `w_data_o` = (cur << off*8) | (hold_q >> (B-off)*8).
  - cur = `w_data_i` in STREAM and 0 in FLUSH.
  - off = 0 degenerates to passthrough, with no hold contribution.
- **Strobes.**
  - Bit j is set iff (first beat → j ≥ off) and (last beat → j < e, or all bits when e = 0).
  - Middle beats get all ones.
  - A single-beat burst applies both conditions.
- **`w_last_o`** = (out_left == 1) while `w_valid_o`.
- **FSM.**
  - IDLE: FIFO empty; all valid/ready outputs are 0. Go to LOAD when count > 0.
  - LOAD: one cycle; latch the head entry, compute counters, clear `hold_q`, pop. Go to STREAM, or back to IDLE/LOAD if nbytes = 0.
  - STREAM:
    - `w_valid_o` = `w_valid_i`; `w_ready_o` = `w_ready_i`.
    - On handshake: `hold_q` ← `w_data_i`, in_left−1, out_left−1.
    - When in_left reaches 0: go to LOAD/IDLE if out_left is also 0, otherwise go to FLUSH.
  - FLUSH:
    - `w_valid_o` = 1; `w_ready_o` = 0; the output uses `hold_q` only.
    - On `w_ready_i`: out_left → 0, then LOAD if the FIFO is non-empty, else IDLE.
- **Backpressure.** `w_valid_o` stable, or `w_data_o`/`w_strb_o`/`w_last_o` changing while `w_valid_o` is high and `w_ready_i` is low, are the upstream's responsibility in STREAM. The block adds no state changes without a handshake. In FLUSH the outputs are held stable by the block.
- **Wrap-around.** FIFO pointers wrap at NumTrackers with no skipped entries.

## Timing
- Reset values:
  - `w_valid_o` = 0, `w_ready_o` = 0, `w_last_o` = 0, `w_strb_o` = 0, `w_data_o` = 0.
  - `cmd_ready_o` = 1 one cycle after reset deassertion and held at 0 during reset.
  - FSM starts in IDLE; all counters, pointers and `hold_q` are 0.
- Data path latency is 0 cycles, combinational from `w_*_i` to `w_*_o`.
- Command to first beat: 2 cycles (push → FIFO non-empty → LOAD → STREAM).
- Per burst overhead:
  - 1 LOAD cycle.
  - Plus 1 FLUSH cycle iff n_out > n_in.
- Reset asserted mid-burst:
  - Everything returns to reset values immediately and the FIFO is emptied.
  - Partial bursts are discarded and nothing is replayed.

## Test plan
- **Aligned burst.** addr 0x1000, nbytes 32 → 2 beats, strb 0xFFFF/0xFFFF, last on beat 2, data equals input, no FLUSH cycle.
- **Misaligned, extra beat.** addr 0x1003, nbytes 16, input bytes 0x00..0x0F →
  - Beat 1: strb 0xFFF8, bytes 3..15 = 0x00..0x0C.
  - Beat 2 (FLUSH): strb 0x0007, bytes 0..2 = 0x0D..0x0F, last = 1.
  - `w_ready_o` = 0 during FLUSH.
- **Single-beat partial.** addr 0x100C, nbytes 4 → 1 beat, strb 0xF000, last = 1.
- **Zero-length and back-to-back commands.** Commands (0x2000, 0) then (0x2005, 40): zero-length produces no beats; second produces 3 beats with strb 0xFFE0, 0xFFFF, 0x1FFF.
- **FIFO full.** Push 4 commands with the output stalled → `cmd_ready_o` = 0 until the first pop. A 5th command is accepted in the cycle after the pop. Order is preserved across pointer wrap.
- **Backpressure and reset.** `w_ready_i` low for 5 cycles in FLUSH holds outputs stable. `rst_ni` pulsed mid-burst → all outputs 0, `cmd_ready_o` = 1 after release, the next command behaves as fresh.
